sort_arbiter: RTL
=================

# sort_arbiter

Packet-level round-robin arbiter that shares one `sort` engine between `NUM_REQ` upstream packet sources in the sink clock domain. It grants one requester at a time, forwards that requester's whole packet (sop..eop) onto the sorter's sink port, and enforces the `MAX_LENGTH` limit by forcing eop and draining any excess words. It sits directly in front of `sort.snk_*`.

## Interface
- `DATA_WIDTH`, 16, word width; matches `sort`.
- `MAX_LENGTH`, 128, maximum words per forwarded packet; matches `sort`.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `snk_clock`  in  1  sole clock.
- `snk_reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_sop`  in  NUM_REQ  per-requester start of packet.
- `req_eop`  in  NUM_REQ  per-requester end of packet.
- `req_data`  in  NUM_REQ x DATA_WIDTH  per-requester word.
- `req_ready`  out  NUM_REQ  per-requester accept.
- `out_valid`, `out_sop`, `out_eop`  out  1  to `sort.snk_valid/sop/eop`.
- `out_data`  out  DATA_WIDTH  to `sort.snk_data`.
- `out_ready`  in  1  from `sort.snk_ready`.
- `grant_valid`  out  1  a packet is granted (STREAM or DRAIN).
- `grant_idx`  out  $clog2(NUM_REQ)  granted requester.
- `pkt_done`  out  1  one-cycle pulse when a forwarded packet's eop transfers.
- `err_trunc`  out  1  one-cycle pulse when eop is forced at `MAX_LENGTH`.
- `err_stray`  out  1  one-cycle pulse when a non-sop word is discarded in IDLE.

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: candidates = `req_valid[i] & req_sop[i]`. Round-robin pick starting at `rr_ptr`; register `grant_idx`, set `rr_ptr = grant_idx+1` (mod NUM_REQ), go STREAM. No data forwarded in IDLE. Any requester with `req_valid & ~req_sop` gets `req_ready=1` (word discarded), `err_stray` pulses (OR over requesters).
- STREAM: `out_*` = granted requester's `req_*` (combinational mux); `req_ready[g] = out_ready`; all other `req_ready` = 0. `out_sop` forced 1 on first word and 0 afterwards regardless of input. Transfer = `out_valid & out_ready`; each transfer increments `len_cnt`.
- Transfer with `req_eop`: `pkt_done` pulses, go IDLE.
- Transfer number `MAX_LENGTH` without `req_eop`: `out_eop` forced 1 on that word, `err_trunc` and `pkt_done` pulse, go DRAIN. Word `MAX_LENGTH` carrying eop naturally: normal completion, no error.
- DRAIN: `out_valid=0`; `req_ready[g]=1`; discard until the word with `req_eop` is accepted (inclusive), then IDLE.
- Single-word packet (sop & eop): forwarded with `out_sop=out_eop=1`.
- `len_cnt` width `$clog2(MAX_LENGTH+1)`; cleared on entry to STREAM.

## Timing
- Reset (`snk_reset_n`=0 at posedge): state IDLE, `rr_ptr=0`, `len_cnt=0`, `grant_idx=0`; all outputs 0 (`req_ready`, `out_*`, `grant_valid`, pulses).
- Reset mid-packet: abandoned with no eop emitted; `sort` is reset alongside.
- Grant latency: sop word valid in IDLE at edge N -> grant registered at N -> first word may transfer at edge N+1. Back-to-back packets: one IDLE cycle between eop and the next sop.
- Forward path is zero-latency combinational (valid/data/ready); only state, `grant_idx`, `rr_ptr`, `len_cnt`, pulses are registered.
- `out_valid` never asserted outside STREAM; `out_data` is don't-care when `out_valid=0`.
- `out_ready` low stalls without loss; the requester holds its word.

## Structure
- Package `sort_pkg`: state enum `arb_state_t` {IDLE, STREAM, DRAIN}, default `DATA_WIDTH`/`MAX_LENGTH` constants shared with `sort`.
- Sub-module `rr_picker`: combinational round-robin priority select (request vector + pointer -> one-hot/index + found flag).

## Test plan
- Reset: hold `snk_reset_n`=0 with all `req_valid`=1 -> all outputs 0, no `req_ready`.
- Req 0 and 2 each send 5-word packets simultaneously after reset, `out_ready`=1 -> req 0 forwarded first (5 words, sop on word 0, eop on word 4), one IDLE cycle, then req 2; two `pkt_done` pulses.
- All 4 requesters continuously offer packets -> grant order 0,1,2,3,0; no requester granted twice in a row while others wait.
- Req 1 sends 130-word packet, `MAX_LENGTH`=128 -> 128 words out, eop on word 128, `err_trunc` pulses once, words 129-130 drained, next grant follows.
- `out_ready` toggled 1/0 every cycle during 10-word packet -> exactly 10 transfers, data order unchanged, no duplication.
- Req 3 sends a word without sop while IDLE -> word accepted and discarded, `err_stray` pulses, `out_valid` stays 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Types and default sizing shared between the sort engine and its front-end arbiter.
package sort_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_MAX_LENGTH = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  // Next requester index, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sort_arbiter.sv
// Packet-level round-robin arbiter feeding one sort engine; enforces MAX_LENGTH by
// forcing eop on the last allowed word and draining the remainder of the packet.
module sort_arbiter
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_LENGTH = DEF_MAX_LENGTH,
  parameter int unsigned NUM_REQ    = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ),
  localparam int unsigned LEN_W     = $clog2(MAX_LENGTH + 1)
) (
  input  logic                               snk_clock,
  input  logic                               snk_reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_sop,
  input  logic [NUM_REQ-1:0]                 req_eop,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               out_valid,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               out_ready,
  output logic                               grant_valid,
  output logic [IDX_W-1:0]                   grant_idx,
  output logic                               pkt_done,
  output logic                               err_trunc,
  output logic                               err_stray
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic             pkt_done_q, pkt_done_d;
  logic             err_trunc_q, err_trunc_d;
  logic             err_stray_q, err_stray_d;

  logic [NUM_REQ-1:0] cand_req;
  logic [NUM_REQ-1:0] stray_req;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               last_slot;
  logic               g_valid;
  logic               g_eop;

  assign cand_req  = req_valid & req_sop;
  assign stray_req = req_valid & ~req_sop;
  assign last_slot = (len_cnt_q == LEN_W'(MAX_LENGTH - 1));
  assign g_valid   = req_valid[grant_q];
  assign g_eop     = req_eop[grant_q];

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (cand_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    len_cnt_d   = len_cnt_q;
    pkt_done_d  = 1'b0;
    err_trunc_d = 1'b0;
    err_stray_d = 1'b0;
    req_ready   = '0;
    out_valid   = 1'b0;
    out_sop     = 1'b0;
    out_eop     = 1'b0;
    out_data    = req_data[grant_q];

    unique case (state_q)
      IDLE: begin
        // Non-sop words cannot start a packet; swallow them so the source unblocks.
        req_ready   = stray_req;
        err_stray_d = |stray_req;
        if (pick_found) begin
          grant_d   = pick_idx;
          rr_ptr_d  = IDX_W'(wrap_inc(32'(pick_idx), NUM_REQ));
          len_cnt_d = '0;
          state_d   = STREAM;
        end
      end

      STREAM: begin
        out_valid          = g_valid;
        out_sop            = (len_cnt_q == '0);
        out_eop            = g_eop | last_slot;
        req_ready[grant_q] = out_ready;
        if (g_valid && out_ready) begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
          if (g_eop) begin
            pkt_done_d = 1'b1;
            state_d    = IDLE;
          end else if (last_slot) begin
            pkt_done_d  = 1'b1;
            err_trunc_d = 1'b1;
            state_d     = DRAIN;
          end
        end
      end

      DRAIN: begin
        req_ready[grant_q] = 1'b1;
        if (g_valid && g_eop) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Keep every output quiet while reset is held, including before the first edge.
    if (!snk_reset_n) begin
      req_ready = '0;
      out_valid = 1'b0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
    end
  end

  always_ff @(posedge snk_clock) begin
    if (!snk_reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      len_cnt_q   <= '0;
      pkt_done_q  <= 1'b0;
      err_trunc_q <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      len_cnt_q   <= len_cnt_d;
      pkt_done_q  <= pkt_done_d;
      err_trunc_q <= err_trunc_d;
      err_stray_q <= err_stray_d;
    end
  end

  assign grant_valid = snk_reset_n & (state_q != IDLE);
  assign grant_idx   = snk_reset_n ? grant_q : '0;
  assign pkt_done    = snk_reset_n & pkt_done_q;
  assign err_trunc   = snk_reset_n & err_trunc_q;
  assign err_stray   = snk_reset_n & err_stray_q;

endmodule
